// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven LOAD/UP/DOWN/HOLD controller for an up/down preset counter
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake; ready only in IDLE
//   cmd_op, cmd_arg                00 LOAD preset, 01 UP steps, 10 DOWN steps, 11 HOLD cycles
//   abort                          kills the running command, pulses aborted
//   count_value                    counter output, captured into result_value in DONE
//   enable_cnt_up/enable_cnt_dn    counter step enables
//   new_cntr_preset(_value)        one-cycle load strobe and held preset value
//   pause_counting                 high whenever not stepping
//   busy, done, aborted            status; done/aborted are one-cycle pulses
module counter_sequencer #(
  parameter int WIDETH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDETH-1:0] cmd_arg,
  input  logic              abort,
  input  logic [WIDETH-1:0] count_value,
  output logic              enable_cnt_up,
  output logic              enable_cnt_dn,
  output logic              new_cntr_preset,
  output logic [WIDETH-1:0] new_cntr_preset_value,
  output logic              pause_counting,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [WIDETH-1:0] result_value
);
  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, HOLD, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDETH-1:0] remaining, remaining_nxt;
  logic accept, active;
  assign accept = cmd_valid & cmd_ready;
  assign active = state inside {LOAD, UP, DOWN, HOLD};
  always_comb begin
    state_nxt = state;
    remaining_nxt = remaining;
    case (state)
      IDLE: if (accept) begin
        remaining_nxt = cmd_arg;
        // a zero-length step/hold command has nothing to do and finishes straight away
        state_nxt = cmd_op == 2'b00 ? LOAD :
                    cmd_arg == '0   ? DONE :
                    cmd_op == 2'b01 ? UP   :
                    cmd_op == 2'b10 ? DOWN : HOLD;
      end
      LOAD: state_nxt = abort ? IDLE : DONE;
      UP, DOWN, HOLD: begin
        remaining_nxt = remaining - 1'b1;
        state_nxt = abort ? IDLE : remaining == 1 ? DONE : state;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      remaining <= '0;
      new_cntr_preset_value <= '0;
      result_value <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_nxt;
      remaining <= remaining_nxt;
      aborted <= abort & active;
      if (accept && cmd_op == 2'b00) new_cntr_preset_value <= cmd_arg;
      if (state == DONE) result_value <= count_value;
    end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign enable_cnt_up = state == UP;
  assign enable_cnt_dn = state == DOWN;
  assign pause_counting = !(state inside {UP, DOWN});
  assign new_cntr_preset = state == LOAD;
  assign done = state == DONE;
endmodule
